char_buf_scan_reader: RTL and testbench

Raster-scan reader for the VGA character buffer on-chip SRAM. It drives the SRAM's second (read-only) port and unpacks each 32-bit word into four 8-bit character codes. It emits the 80x60 visible characters as one Avalon-ST packet per frame with valid/ready backpressure. It sits between the character buffer RAM and the character-to-pixel renderer.

---
 rtl/char_buf_scan_reader.sv | 184 ++++++++++++++++++
 tb/tb_char_buf_scan_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_buf_scan_reader.sv
// Raster-scan reader for the VGA character buffer SRAM (port 2, read-only).
// Reads one 32-bit word per four characters and streams the visible
// COLS x ROWS characters as one valid/ready packet per frame.
// Optional build macro: CHAR_BUF_SCAN_READER_PREFETCH_EN (reads the next
// word while the current one drains, removing the per-word bubble).
module char_buf_scan_reader #(
  parameter int COLS             = 80,
  parameter int ROWS             = 60,
  parameter int ROW_STRIDE_WORDS = 32,
  parameter int ADDR_W           = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] address2,
  output logic              chipselect2,
  output logic              clken2,
  output logic              write2,
  output logic [3:0]        byteenable2,
  output logic [31:0]       writedata2,
  input  logic [31:0]       readdata2,
  output logic [7:0]        char_data,
  output logic              char_valid,
  input  logic              char_ready,
  output logic              char_sop,
  output logic              char_eop
);

  localparam int WORDS_PER_ROW = COLS / 4;
  localparam int COL_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_EMIT} state_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d, row_nxt;
  logic [COL_W-1:0]  col_q, col_d, col_nxt;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       word_q, word_d;
  logic              last_col, last_word;

`ifdef CHAR_BUF_SCAN_READER_PREFETCH_EN
  logic [31:0]       pf_q, pf_d;
  logic              pf_issued_q, pf_issued_d;
  logic              pf_cap_q, pf_cap_d;
`endif

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
    return ADDR_W'(r) * ADDR_W'(ROW_STRIDE_WORDS) + ADDR_W'(c);
  endfunction

  assign clken2      = 1'b1;
  assign write2      = 1'b0;
  assign byteenable2 = '1;
  assign writedata2  = '0;

  // Position bookkeeping: where the word after the current one lives.
  always_comb begin
    last_col  = (col_q == COL_W'(WORDS_PER_ROW - 1));
    last_word = last_col && (row_q == ROW_W'(ROWS - 1));
    col_nxt   = last_col ? '0 : col_q + COL_W'(1);
    row_nxt   = last_col ? row_q + ROW_W'(1) : row_q;
  end

  // Character stream outputs decoded from the word register and position.
  always_comb begin
    char_valid = (state_q == S_EMIT);
    busy       = (state_q != S_IDLE);
    case (idx_q)
      2'd0:    char_data = word_q[7:0];
      2'd1:    char_data = word_q[15:8];
      2'd2:    char_data = word_q[23:16];
      default: char_data = word_q[31:24];
    endcase
    char_sop = char_valid && (row_q == '0) && (col_q == '0) && (idx_q == 2'd0);
    char_eop = char_valid && last_word && (idx_q == 2'd3);
  end

  // Next-state, SRAM strobe and word/counter updates.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    idx_d       = idx_q;
    word_d      = word_q;
    chipselect2 = 1'b0;
    address2    = word_addr(row_q, col_q);
`ifdef CHAR_BUF_SCAN_READER_PREFETCH_EN
    pf_d        = pf_cap_q ? readdata2 : pf_q;
    pf_issued_d = pf_issued_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          row_d   = '0;
          col_d   = '0;
          idx_d   = '0;
        end
      end
      S_ISSUE: begin
        chipselect2 = 1'b1;
        state_d     = S_CAPTURE;
      end
      S_CAPTURE: begin
        word_d  = readdata2;
        idx_d   = '0;
        state_d = S_EMIT;
`ifdef CHAR_BUF_SCAN_READER_PREFETCH_EN
        pf_issued_d = 1'b0;
`endif
      end
      default: begin
`ifdef CHAR_BUF_SCAN_READER_PREFETCH_EN
        // One outstanding prefetch per word; a stalled sink cannot trigger another.
        if (!pf_issued_q && !last_word) begin
          chipselect2 = 1'b1;
          address2    = word_addr(row_nxt, col_nxt);
          pf_issued_d = 1'b1;
        end
`endif
        if (char_ready) begin
          if (idx_q == 2'd3) begin
            idx_d = '0;
            if (last_word) begin
              state_d = S_IDLE;
              row_d   = '0;
              col_d   = '0;
            end else begin
              row_d = row_nxt;
              col_d = col_nxt;
`ifdef CHAR_BUF_SCAN_READER_PREFETCH_EN
              word_d      = pf_q;
              pf_issued_d = 1'b0;
`else
              state_d = S_ISSUE;
`endif
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
    endcase
  end

`ifdef CHAR_BUF_SCAN_READER_PREFETCH_EN
  // Read data arrives the cycle after the prefetch strobe.
  assign pf_cap_d = (state_q == S_EMIT) && chipselect2;

  // Prefetch register and its read-tracking flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pf_q        <= '0;
      pf_issued_q <= 1'b0;
      pf_cap_q    <= 1'b0;
    end else begin
      pf_q        <= pf_d;
      pf_issued_q <= pf_issued_d;
      pf_cap_q    <= pf_cap_d;
    end
  end
`endif

  // State, position counters and current word register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_char_buf_scan_reader.sv
// Self-checking bench for char_buf_scan_reader: SRAM model with random
// contents, expected character/address streams built from the frame layout.
module tb_char_buf_scan_reader;

  localparam int COLS = 80;
  localparam int ROWS = 60;
  localparam int STRIDE = 32;
  localparam int ADDR_W = 11;
  localparam int NCHARS = COLS * ROWS;
  localparam int NREADS = NCHARS / 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              busy;
  logic [ADDR_W-1:0] address2;
  logic              chipselect2;
  logic              clken2;
  logic              write2;
  logic [3:0]        byteenable2;
  logic [31:0]       writedata2;
  logic [31:0]       readdata2;
  logic [7:0]        char_data;
  logic              char_valid;
  logic              char_ready;
  logic              char_sop;
  logic              char_eop;

  char_buf_scan_reader #(
    .COLS(COLS), .ROWS(ROWS), .ROW_STRIDE_WORDS(STRIDE), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy),
    .address2(address2), .chipselect2(chipselect2), .clken2(clken2),
    .write2(write2), .byteenable2(byteenable2), .writedata2(writedata2),
    .readdata2(readdata2), .char_data(char_data), .char_valid(char_valid),
    .char_ready(char_ready), .char_sop(char_sop), .char_eop(char_eop)
  );

  always #5 clk = ~clk;

  // SRAM port 2: registered read, data valid the cycle after the strobe.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (chipselect2) readdata2 <= mem[address2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Monitor state.
  int   cyc = 0;
  int   ready_mode = 0;     // 0: always ready, 1: 1,0,0,1 pattern, 2: random
  int   restart_at = -1;    // pulse start when this many chars were accepted
  bit   start_on_eop = 0;   // pulse start together with the final transfer
  bit   start_now = 0;
  bit   rst_now = 0;
  logic [7:0]        got_q[$];
  logic [7:0]        exp_q[$];
  logic [ADDR_W-1:0] addr_log[$];
  logic [ADDR_W-1:0] exp_addr[$];
  int   sop_idx[$];
  int   eop_idx[$];
  int   hold_err, proto_err, valid_cycles;
  int   first_valid_cyc, first_cs_cyc, eop_cyc, start_cyc;
  bit   hold_pend;
  logic [9:0] held;

  // One clock cycle: drive inputs at the falling edge, then observe.
  task automatic tick();
    @(negedge clk);
    cyc++;
    case (ready_mode)
      0:       char_ready = 1'b1;
      1:       char_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: char_ready = 1'($urandom_range(0, 1));
    endcase
    reset_n = !rst_now;
    start = start_now
         || (restart_at >= 0 && char_valid && got_q.size() == restart_at)
         || (start_on_eop && char_valid && char_eop && char_ready);
    start_now = 0;
    #1;
    if (chipselect2) begin
      if (first_cs_cyc < 0) first_cs_cyc = cyc;
      addr_log.push_back(address2);
    end
    if (hold_pend && !(char_valid && {char_sop, char_eop, char_data} == held)) hold_err++;
    hold_pend = 0;
    if (!char_valid && (char_sop || char_eop)) proto_err++;
    if (char_valid) begin
      valid_cycles++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (char_ready) begin
        if (char_sop) sop_idx.push_back(got_q.size());
        if (char_eop) begin
          eop_idx.push_back(got_q.size());
          eop_cyc = cyc;
        end
        got_q.push_back(char_data);
      end else begin
        hold_pend = 1;
        held = {char_sop, char_eop, char_data};
      end
    end
  endtask

  task automatic rand_mem();
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
    mem[0]      = 32'h4443_4241;
    mem[11'h773] = 32'h5A59_5857;
  endtask

  // Reference: row-major scan, 4 chars per word, lowest x in the low byte.
  task automatic build_expected();
    logic [31:0] w;
    exp_q.delete();
    exp_addr.delete();
    for (int r = 0; r < ROWS; r++) begin
      for (int x = 0; x < COLS; x++) begin
        w = mem[r * STRIDE + x / 4];
        exp_q.push_back(w[8 * (x % 4) +: 8]);
      end
      for (int c = 0; c < COLS / 4; c++) exp_addr.push_back(ADDR_W'(r * STRIDE + c));
    end
  endtask

  task automatic clear_logs();
    got_q.delete(); addr_log.delete(); sop_idx.delete(); eop_idx.delete();
    hold_err = 0; proto_err = 0; valid_cycles = 0; hold_pend = 0;
    first_valid_cyc = -1; first_cs_cyc = -1; eop_cyc = -1;
  endtask

  task automatic run_frame(input bit chained_in, input bit chain_out);
    clear_logs();
    if (chained_in) start_cyc = cyc;
    else begin
      start_now = 1;
      tick();
      start_cyc = cyc;
    end
    for (int n = 0; n < 20000 && eop_idx.size() == 0; n++) tick();
    start_now = chain_out;
    tick();
    chk("busy_after_eop", {31'd0, busy}, 32'd0);
    chk("valid_after_eop", {31'd0, char_valid}, 32'd0);
    if (start_on_eop) begin
      tick();
      chk("start_on_eop_ignored", {30'd0, chipselect2, busy}, 32'd0);
    end
  endtask

  task automatic check_frame(input string tag);
    int bad;
    chk({tag, "_nchars"}, got_q.size(), NCHARS);
    bad = 0;
    for (int i = 0; i < NCHARS; i++) if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    chk({tag, "_data_mismatches"}, bad, 0);
    chk({tag, "_first_char"}, {24'd0, got_q[0]}, 32'h41);
    chk({tag, "_last_char"}, {24'd0, got_q[got_q.size() - 1]}, 32'h5A);
    chk({tag, "_sop_pos"}, (sop_idx.size() == 1) ? sop_idx[0] : -1, 0);
    chk({tag, "_eop_pos"}, (eop_idx.size() == 1) ? eop_idx[0] : -1, NCHARS - 1);
    chk({tag, "_nreads"}, addr_log.size(), NREADS);
    bad = 0;
    for (int i = 0; i < NREADS; i++) if (i >= addr_log.size() || addr_log[i] !== exp_addr[i]) bad++;
    foreach (addr_log[i]) if (int'(addr_log[i]) % STRIDE >= COLS / 4) bad++;
    chk({tag, "_addr_mismatches"}, bad, 0);
    chk({tag, "_hold_violations"}, hold_err, 0);
    chk({tag, "_sop_eop_without_valid"}, proto_err, 0);
    chk({tag, "_cs_latency"}, first_cs_cyc - start_cyc, 1);
    chk({tag, "_valid_latency"}, first_valid_cyc - start_cyc, 3);
  endtask

  task automatic check_throughput(input string tag);
    int span;
    span = eop_cyc - first_valid_cyc + 1;
`ifdef CHAR_BUF_SCAN_READER_PREFETCH_EN
    chk({tag, "_span"}, span, NCHARS);
    chk({tag, "_valid_cycles"}, valid_cycles, NCHARS);
`else
    chk({tag, "_span_7200pm2"}, {31'd0, (span >= 7198 && span <= 7202)}, 32'd1);
`endif
  endtask

  typedef struct {
    int ready_mode;
    int restart_at;
    bit start_on_eop;
  } vec_t;
  vec_t vecs[4];

  initial begin
    vecs[0] = '{ready_mode: 0, restart_at: -1,  start_on_eop: 1'b0};
    vecs[1] = '{ready_mode: 1, restart_at: -1,  start_on_eop: 1'b0};
    vecs[2] = '{ready_mode: 2, restart_at: 100, start_on_eop: 1'b0};
    vecs[3] = '{ready_mode: 0, restart_at: 100, start_on_eop: 1'b1};

    reset_n = 1'b0; start = 1'b0; char_ready = 1'b0;
    clear_logs();
    rand_mem();
    build_expected();

    // Reset values and tied-off port-2 controls.
    rst_now = 1;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cs", {31'd0, chipselect2}, 32'd0);
    chk("rst_valid_sop_eop", {29'd0, char_valid, char_sop, char_eop}, 32'd0);
    chk("rst_address", {21'd0, address2}, 32'd0);
    chk("rst_char_data", {24'd0, char_data}, 32'd0);
    chk("tied_port2", {write2, clken2, byteenable2, writedata2[25:0]}, {1'b0, 1'b1, 4'hF, 26'd0});
    rst_now = 0;
    tick();

    foreach (vecs[v]) begin
      rand_mem();
      build_expected();
      ready_mode   = vecs[v].ready_mode;
      restart_at   = vecs[v].restart_at;
      start_on_eop = vecs[v].start_on_eop;
      run_frame(1'b0, 1'b0);
      check_frame($sformatf("vec%0d", v));
      if (ready_mode == 0) check_throughput($sformatf("vec%0d", v));
      tick();
    end
    restart_at = -1;
    start_on_eop = 0;

    // Start one cycle after busy falls begins a new frame at word 0.
    ready_mode = 2;
    rand_mem();
    build_expected();
    run_frame(1'b0, 1'b1);
    check_frame("chain_a");
    run_frame(1'b1, 1'b0);
    check_frame("chain_b");
    chk("chain_b_first_addr", {21'd0, addr_log[0]}, 32'd0);

    // Reset mid-frame abandons the packet; a fresh start restarts cleanly.
    ready_mode = 0;
    clear_logs();
    start_now = 1;
    tick();
    for (int n = 0; n < 20000 && got_q.size() < 2000; n++) tick();
    rst_now = 1;
    tick();
    rst_now = 0;
    tick();
    chk("midrst_valid", {31'd0, char_valid}, 32'd0);
    chk("midrst_cs", {31'd0, chipselect2}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    run_frame(1'b0, 1'b0);
    check_frame("after_rst");
    chk("after_rst_first_addr", {21'd0, addr_log[0]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
